// File: rtl/spi_image_transfer_ctrl.sv
// spi_image_transfer_ctrl
// Decodes SPI command bytes and moves image data between the SPI byte stream
// and the per-channel image BRAM. It also launches PDI runs under an optional
// watchdog and keeps a status byte with sticky error flags.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   spi_cycle_done  - one-cycle pulse per completed SPI byte
//   spi_byte_in     - byte received from spi_slave
//   spi_byte_out    - byte returned on the next SPI transfer
//   bram_addr       - BRAM address (write pointer or read address)
//   bram_channel    - channel select (01 R, 10 G, 11 B)
//   bram_we         - one-cycle write strobe per pixel byte
//   bram_data_in    - BRAM write data
//   bram_data_out   - BRAM read data, valid one clock after bram_addr changes
//   pdi_active      - PDI run request (level)
//   pdi_done        - PDI completion pulse
module spi_image_transfer_ctrl #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DIM_W       = 16,
  parameter int unsigned MAX_PIXELS  = 76800,
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned PDI_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cycle_done,
  input  logic [7:0]        spi_byte_in,
  output logic [7:0]        spi_byte_out,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [1:0]        bram_channel,
  output logic              bram_we,
  output logic [7:0]        bram_data_in,
  input  logic [7:0]        bram_data_out,
  output logic              pdi_active,
  input  logic              pdi_done
);

  localparam int unsigned PROD_W = 2 * DIM_W;
  localparam int unsigned CNT_W  = $clog2(MAX_PIXELS + 1);
  localparam int unsigned WD_W   = (PDI_TIMEOUT > 1) ? $clog2(PDI_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZE,
    S_WRITE,
    S_READ,
    S_PDI
  } state_t;

  state_t            state;
  logic              err_cmd;
  logic              err_size;
  logic              err_to;
  logic [1:0]        byte_cnt;
  logic [23:0]       size_buf;
  logic [CNT_W-1:0]  pixel_count;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] wr_ptr;
  logic [WD_W-1:0]   wd;

  logic [1:0]        cmd_op;
  logic [1:0]        cmd_ch;
  logic              ch_ok;
  logic [7:0]        status;
  logic [DIM_W-1:0]  dim_h;
  logic [DIM_W-1:0]  dim_w;
  logic [PROD_W-1:0] product;
  logic              size_bad;
  logic              wd_expired;

  // Command decode, status byte and size check helpers
  always_comb begin
    cmd_op     = spi_byte_in[3:2];
    cmd_ch     = spi_byte_in[1:0];
    ch_ok      = (cmd_ch != 2'd0) && (32'(cmd_ch) <= NUM_CH);
    status     = {(state == S_PDI), err_size, err_cmd, err_to, 2'b00, bram_channel};
    // Height is fully buffered; width's low byte is the byte arriving now
    dim_h      = DIM_W'(size_buf[23:8]);
    dim_w      = DIM_W'({size_buf[7:0], spi_byte_in});
    product    = PROD_W'(dim_h) * PROD_W'(dim_w);
    size_bad   = (dim_h == '0) || (dim_w == '0) || (product > PROD_W'(MAX_PIXELS));
    // Expires on the PDI_TIMEOUT-th clock after entering PDI
    wd_expired = (PDI_TIMEOUT != 0) && ((32'(wd) + 32'd1) >= PDI_TIMEOUT);
  end

  // Controller state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      spi_byte_out <= 8'h00;
      bram_addr    <= '0;
      bram_channel <= 2'b00;
      bram_we      <= 1'b0;
      bram_data_in <= 8'h00;
      pdi_active   <= 1'b0;
      err_cmd      <= 1'b0;
      err_size     <= 1'b0;
      err_to       <= 1'b0;
      byte_cnt     <= 2'd0;
      size_buf     <= 24'h0;
      pixel_count  <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      wd           <= '0;
    end else begin
      bram_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (spi_cycle_done) begin
            // Status and PDI commands carry no channel, so only read/write
            // commands are channel-checked
            if ((cmd_op == 2'b01 || cmd_op == 2'b10) && !ch_ok) begin
              err_cmd <= 1'b1;
            end else begin
              unique case (cmd_op)
                2'b00: begin
                  spi_byte_out <= status;
                  err_cmd      <= 1'b0;
                  err_size     <= 1'b0;
                  err_to       <= 1'b0;
                end
                2'b01: begin
                  bram_channel <= cmd_ch;
                  byte_cnt     <= 2'd0;
                  state        <= S_SIZE;
                end
                2'b10: begin
                  bram_channel <= cmd_ch;
                  bram_addr    <= '0;
                  remaining    <= (pixel_count != '0) ? pixel_count : CNT_W'(MAX_PIXELS);
                  state        <= S_READ;
                end
                default: begin
                  pdi_active <= 1'b1;
                  wd         <= '0;
                  state      <= S_PDI;
                end
              endcase
            end
          end
        end

        S_SIZE: begin
          if (spi_cycle_done) begin
            size_buf <= {size_buf[15:0], spi_byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (size_bad) begin
                err_size <= 1'b1;
                state    <= S_IDLE;
              end else begin
                pixel_count <= CNT_W'(product);
                remaining   <= CNT_W'(product);
                wr_ptr      <= '0;
                state       <= S_WRITE;
              end
            end
          end
        end

        S_WRITE: begin
          if (spi_cycle_done) begin
            bram_data_in <= spi_byte_in;
            bram_addr    <= wr_ptr;
            bram_we      <= 1'b1;
            wr_ptr       <= wr_ptr + ADDR_W'(1);
            remaining    <= remaining - CNT_W'(1);
            if (remaining <= CNT_W'(1)) state <= S_IDLE;
          end
        end

        S_READ: begin
          if (spi_cycle_done) begin
            spi_byte_out <= bram_data_out;
            bram_addr    <= bram_addr + ADDR_W'(1);
            remaining    <= remaining - CNT_W'(1);
            if (remaining <= CNT_W'(1)) state <= S_IDLE;
          end
        end

        S_PDI: begin
          if (pdi_done) begin
            // Completion wins over a coincident SPI byte and watchdog expiry
            pdi_active <= 1'b0;
            state      <= S_IDLE;
            if (spi_cycle_done) spi_byte_out <= {1'b0, status[6:0]};
          end else if (wd_expired) begin
            pdi_active <= 1'b0;
            err_to     <= 1'b1;
            state      <= S_IDLE;
            if (spi_cycle_done) spi_byte_out <= 8'h80 | status;
          end else begin
            if (PDI_TIMEOUT != 0) wd <= wd + WD_W'(1);
            if (spi_cycle_done) spi_byte_out <= 8'h80 | status;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_image_transfer_ctrl.sv
// Scoreboard bench for spi_image_transfer_ctrl: stimulus pushes expected BRAM
// writes and SPI responses into queues; a monitor pops and compares them.
module tb_spi_image_transfer_ctrl;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_cycle_done;
  logic [7:0]        spi_byte_in;
  logic [7:0]        spi_byte_out;
  logic [ADDR_W-1:0] bram_addr;
  logic [1:0]        bram_channel;
  logic              bram_we;
  logic [7:0]        bram_data_in;
  logic [7:0]        bram_data_out;
  logic              pdi_active;
  logic              pdi_done;

  always #5 clk = ~clk;

  spi_image_transfer_ctrl #(
    .ADDR_W(ADDR_W), .DIM_W(16), .MAX_PIXELS(76800), .NUM_CH(3), .PDI_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst),
    .spi_cycle_done(spi_cycle_done), .spi_byte_in(spi_byte_in), .spi_byte_out(spi_byte_out),
    .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out),
    .pdi_active(pdi_active), .pdi_done(pdi_done)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ch;
    logic [7:0]        data;
  } wr_t;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } resp_t;

  wr_t   wr_q[$];
  resp_t resp_q[$];
  wr_t   wr_exp;
  resp_t rs_exp;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    act_cnt = 0;
  logic  due = 1'b0;

  // Simple BRAM model: synchronous write, one-clock read latency
  logic [7:0] mem [4][256];
  always @(posedge clk) begin
    if (bram_we) mem[bram_channel][bram_addr[7:0]] <= bram_data_in;
    bram_data_out <= mem[bram_channel][bram_addr[7:0]];
  end

  // Clocks during which pdi_active was high
  always @(posedge clk) if (pdi_active) act_cnt <= act_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: BRAM write strobes and SPI responses one clock after each byte
  always @(posedge clk) due <= spi_cycle_done & ~rst;

  always @(negedge clk) begin
    if (bram_we) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h, expected no write", bram_addr, bram_data_in);
      end else begin
        wr_exp = wr_q.pop_front();
        check("we_addr", 32'(bram_addr), 32'(wr_exp.addr));
        check("we_ch", 32'(bram_channel), 32'(wr_exp.ch));
        check("we_data", 32'(bram_data_in), 32'(wr_exp.data));
      end
    end
    if (due) begin
      if (resp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no SPI byte", spi_byte_out);
      end else begin
        rs_exp = resp_q.pop_front();
        if (rs_exp.chk) check("spi_byte_out", 32'(spi_byte_out), 32'(rs_exp.val));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic chk, input logic [7:0] exp);
    resp_q.push_back(resp_t'({chk, exp}));
    @(posedge clk); #1;
    spi_byte_in    = b;
    spi_cycle_done = 1'b1;
    @(posedge clk); #1;
    spi_cycle_done = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr_pixel(input logic [ADDR_W-1:0] a, input logic [1:0] ch, input logic [7:0] d);
    wr_q.push_back(wr_t'({a, ch, d}));
    send_byte(d, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spi_byte_out"}, 32'(spi_byte_out), 32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_bram_channel"}, 32'(bram_channel), 32'd0);
    check({tag, "_bram_we"}, 32'(bram_we), 32'd0);
    check({tag, "_bram_data_in"}, 32'(bram_data_in), 32'd0);
    check({tag, "_pdi_active"}, 32'(pdi_active), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start_cnt;
    int k;
    rst            = 1'b1;
    spi_cycle_done = 1'b0;
    spi_byte_in    = 8'h00;
    pdi_done       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 rst = 1'b0;

    // Write 2x3 image into channel R
    send_byte(8'h05, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h02, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h03, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) wr_pixel(ADDR_W'(i), 2'b01, 8'(8'h10 + i));

    // Read it back; the 7th byte is a status query (ch 01, no errors)
    send_byte(8'h09, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b1, 8'(8'h10 + i));
    send_byte(8'h00, 1'b1, 8'h01);

    // Oversize 320x321 on channel G: no writes, err_size then cleared
    send_byte(8'h06, 1'b0, 8'h00);
    send_byte(8'h01, 1'b0, 8'h00);
    send_byte(8'h40, 1'b0, 8'h00);
    send_byte(8'h01, 1'b0, 8'h00);
    send_byte(8'h41, 1'b0, 8'h00);
    send_byte(8'h00, 1'b1, 8'h42);
    send_byte(8'h00, 1'b1, 8'h02);

    // Channel 0 write command: err_cmd, stays in IDLE
    send_byte(8'h04, 1'b0, 8'h00);
    send_byte(8'h00, 1'b1, 8'h22);

    // Zero height on channel B: err_size
    send_byte(8'h07, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h05, 1'b0, 8'h00);
    send_byte(8'h00, 1'b1, 8'h43);

    // PDI with no completion: watchdog ends it after 50 clocks
    start_cnt = act_cnt;
    send_byte(8'h0C, 1'b0, 8'h00);
    check("pdi_active_start", 32'(pdi_active), 32'd1);
    send_byte(8'hAA, 1'b1, 8'h83);
    k = 0;
    while (pdi_active && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("pdi_timeout_drop", 32'(pdi_active), 32'd0);
    check("pdi_active_cycles", 32'(act_cnt - start_cnt), 32'd50);
    send_byte(8'h00, 1'b1, 8'h13);
    send_byte(8'h00, 1'b1, 8'h03);

    // PDI completion coincident with an SPI byte
    send_byte(8'h0C, 1'b0, 8'h00);
    resp_q.push_back(resp_t'({1'b1, 8'h03}));
    @(posedge clk); #1;
    pdi_done       = 1'b1;
    spi_cycle_done = 1'b1;
    spi_byte_in    = 8'h55;
    @(posedge clk); #1;
    pdi_done       = 1'b0;
    spi_cycle_done = 1'b0;
    check("pdi_done_drop", 32'(pdi_active), 32'd0);
    @(posedge clk);
    send_byte(8'h00, 1'b1, 8'h03);

    // pdi_done outside PDI is ignored
    @(posedge clk); #1 pdi_done = 1'b1;
    @(posedge clk); #1 pdi_done = 1'b0;
    check("pdi_done_idle", 32'(pdi_active), 32'd0);
    send_byte(8'h00, 1'b1, 8'h03);

    // Reset in the middle of a 1x4 write on channel R
    send_byte(8'h05, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h01, 1'b0, 8'h00);
    send_byte(8'h00, 1'b0, 8'h00);
    send_byte(8'h04, 1'b0, 8'h00);
    wr_pixel(ADDR_W'(0), 2'b01, 8'hA0);
    wr_pixel(ADDR_W'(1), 2'b01, 8'hA1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_write_reset");
    @(posedge clk); #1 rst = 1'b0;

    // Stored count cleared: read runs past 4 bytes into older data
    send_byte(8'h09, 1'b0, 8'h00);
    send_byte(8'h00, 1'b1, 8'hA0);
    send_byte(8'h00, 1'b1, 8'hA1);
    send_byte(8'h00, 1'b1, 8'h12);
    send_byte(8'h00, 1'b1, 8'h13);
    send_byte(8'h00, 1'b1, 8'h14);

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
